// File: rtl/regfile_wr_arbiter.sv
// Two-source arbiter for the RegisterFile write port: fixed priority to p0 with a p1 starvation guard.
// Optional pending-write scoreboard enabled by defining RF_ARB_SCOREBOARD_EN.
module regfile_wr_arbiter #(
  parameter int AW           = 5,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic [AW-1:0]     p0_rd,
  input  logic [DW-1:0]     p0_wd,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic [AW-1:0]     p1_rd,
  input  logic [DW-1:0]     p1_wd,
  output logic              rf_we,
  output logic [AW-1:0]     rf_rd,
  output logic [DW-1:0]     rf_wd,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_rd,
  output logic [2**AW-1:0]  busy
);

  localparam int          SW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_q, starve_d;
  logic          rf_we_q;
  logic [AW-1:0] rf_rd_q;
  logic [DW-1:0] rf_wd_q;

  logic          p1_starved;
  logic          xfer;
  logic [AW-1:0] sel_rd;
  logic [DW-1:0] sel_wd;

  always_comb begin
    p1_starved = p1_valid && (starve_q == LIMIT_C);
    p0_ready   = !rst && p0_valid && !p1_starved;
    p1_ready   = !rst && p1_valid && !(p0_valid && !p1_starved);
    xfer       = p0_ready || p1_ready;
    sel_rd     = p0_ready ? p0_rd : p1_rd;
    sel_wd     = p0_ready ? p0_wd : p1_wd;

    starve_d = starve_q;
    if (!p1_valid || p1_ready) begin
      starve_d = '0;
    end else if (starve_q != LIMIT_C) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      rf_we_q  <= 1'b0;
      rf_rd_q  <= '0;
      rf_wd_q  <= '0;
    end else begin
      starve_q <= starve_d;
      // Writes to x0 complete the handshake but never reach the RegisterFile.
      rf_we_q  <= xfer && (sel_rd != '0);
      if (xfer) begin
        rf_rd_q <= sel_rd;
        rf_wd_q <= sel_wd;
      end
    end
  end

  // A write staged last cycle is squashed if reset arrives before the RegisterFile commits it.
  assign rf_we = rf_we_q && !rst;
  assign rf_rd = rf_rd_q;
  assign rf_wd = rf_wd_q;

`ifdef RF_ARB_SCOREBOARD_EN
  logic [2**AW-1:0] busy_q, busy_d;

  generate
    for (genvar gi = 0; gi < 2**AW; gi++) begin : g_busy
      if (gi == 0) begin : g_x0
        assign busy_d[gi] = 1'b0;
      end else begin : g_xn
        // A new issue to the same register overrides the retiring write's clear.
        assign busy_d[gi] = (issue_valid && (issue_rd == AW'(gi))) ||
                            (busy_q[gi] && !(rf_we && (rf_rd == AW'(gi))));
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
`else
  logic unused_issue;
  assign unused_issue = ^{issue_valid, issue_rd};
  assign busy = '0;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed plus random bench for regfile_wr_arbiter against a cycle-level behavioural model.
// Scoreboard expectations follow RF_ARB_SCOREBOARD_EN the same way the design does.
module tb_regfile_wr_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_valid, p1_valid, p0_ready, p1_ready;
  logic [AW-1:0] p0_rd, p1_rd, rf_rd, issue_rd;
  logic [DW-1:0] p0_wd, p1_wd, rf_wd;
  logic          rf_we, issue_valid;
  logic [31:0]   busy;

  regfile_wr_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_rd(p0_rd), .p0_wd(p0_wd),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_rd(p1_rd), .p1_wd(p1_wd),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  // RegisterFile fed by the DUT's write port; x0 is never written.
  logic [DW-1:0] tb_rf [32];
  always @(posedge clk) begin
    if (rf_we === 1'b1 && rf_rd != '0) tb_rf[rf_rd] <= rf_wd;
  end

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [DW-1:0] m_rf [32];
  int            m_wait;
  bit            m_we;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_wd;
  logic [31:0]   m_busy;
  bit            known;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r,
                      input bit v0, input logic [AW-1:0] rd0, input logic [DW-1:0] wd0,
                      input bit v1, input logic [AW-1:0] rd1, input logic [DW-1:0] wd1,
                      input bit iv, input logic [AW-1:0] ird);
    bit e0, e1;
    rst = r; p0_valid = v0; p0_rd = rd0; p0_wd = wd0;
    p1_valid = v1; p1_rd = rd1; p1_wd = wd1; issue_valid = iv; issue_rd = ird;
    #4;
    e0 = !r && v0 && !(v1 && m_wait >= LIMIT);
    e1 = !r && v1 && !e0;
    chk("p0_ready", p0_ready, e0);
    chk("p1_ready", p1_ready, e1);
    chk("rf_we", rf_we, m_we && !r);
    if (known) begin
      chk("rf_rd", rf_rd, m_rd);
      chk("rf_wd", rf_wd, m_wd);
      chk("busy", busy, m_busy);
    end
    $display("t=%0t rst=%0d p0=%0d/%0d p1=%0d/%0d we=%0d rd=%0d wd=%08h busy=%08h",
             $time, r, v0, p0_ready, v1, p1_ready, rf_we, rf_rd, rf_wd, busy);
    @(posedge clk);
    if (r) begin
      m_wait = 0; m_we = 0; m_rd = '0; m_wd = '0; m_busy = '0; known = 1;
    end else begin
      if (m_we) m_rf[m_rd] = m_wd;
`ifdef RF_ARB_SCOREBOARD_EN
      if (m_we) m_busy[m_rd] = 1'b0;
      if (iv && ird != '0) m_busy[ird] = 1'b1;
`endif
      if (!v1 || e1) m_wait = 0;
      else if (m_wait < LIMIT) m_wait++;
      if (e0 || e1) begin
        m_rd = e0 ? rd0 : rd1;
        m_wd = e0 ? wd0 : wd1;
        m_we = (m_rd != '0);
      end else begin
        m_we = 0;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      tb_rf[i] = '0;
      m_rf[i] = '0;
    end
    m_wait = 0; m_we = 0; m_rd = '0; m_wd = '0; m_busy = '0; known = 0;
    rst = 1; p0_valid = 0; p1_valid = 0; p0_rd = '0; p1_rd = '0;
    p0_wd = '0; p1_wd = '0; issue_valid = 0; issue_rd = '0;
    @(posedge clk); #1;

    // Reset with requests present: no grants while in reset
    step(1, 1, 3, 32'h1, 1, 4, 32'h2, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Single p0 write, x5
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    idle(2);

    // Simultaneous p0 x3 / p1 x4; p1 wins once p0 goes idle
    step(0, 1, 3, 32'h3333, 1, 4, 32'h4444, 0, 0);
    step(0, 0, 0, 0, 1, 4, 32'h4444, 0, 0);
    idle(2);

    // Starvation: p1 loses LIMIT cycles, wins next, then the pattern repeats
    for (int k = 0; k < 2 * (LIMIT + 1); k++)
      step(0, 1, 5'(10 + k % 4), 32'hA000 + k, 1, 20, 32'hB000 + k, 0, 0);
    idle(2);

    // Write to x0 completes but never asserts rf_we
    step(0, 1, 0, 32'h1234, 0, 0, 0, 0, 0);
    idle(2);

    // Reset right after acceptance drops the staged x7 write
    step(0, 1, 7, 32'h55, 0, 0, 0, 0, 0);
    step(1, 1, 7, 32'h66, 1, 8, 32'h77, 0, 0);
    idle(2);

    // Scoreboard: issue x9, write x9 via p1, re-issue during the retire cycle, then clear
    step(0, 0, 0, 0, 0, 0, 0, 1, 9);
    step(0, 0, 0, 0, 1, 9, 32'h99, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 9);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 9, 32'h9A, 0, 0, 0, 0, 0);
    idle(2);

    // Random traffic over a small register range to force collisions and x0 writes
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)));
    end
    idle(3);

    for (int i = 0; i < 32; i++) chk($sformatf("rf_x%0d", i), tb_rf[i], m_rf[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
